// File: rtl/branch_pkg.sv
// branch_pkg: shared counter/state types and the sequential PC step for the branch predictor
package branch_pkg;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_t;
  typedef enum logic {INIT = 1'b0, RUN = 1'b1} bp_state_t;
  localparam int PC_STEP = 4;
endpackage

// File: rtl/bp_sat_counter.sv
// bp_sat_counter: next state of a 2-bit saturating counter (cur, taken, force_st -> nxt)
module bp_sat_counter
  import branch_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  input  logic       force_st,
  output logic [1:0] nxt
);
  assign nxt = force_st ? ST :
               taken    ? ((cur == ST)  ? ST  : cur + 2'd1) :
                          ((cur == SNT) ? SNT : cur - 2'd1);
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: BHT+BTB fetch predictor with execute-side training and mispredict redirect.
// Ports: clk/rst_n (async active-low); f_valid/f_pc/f_ready lookup request;
// pred_valid/pred_taken/pred_target registered prediction; r_* resolved branch info;
// mispredict/redirect_pc one-cycle redirect. Macro BP_STATS_EN adds stat_branches/stat_mispredicts.
module branch_predictor
  import branch_pkg::*;
#(
  parameter  int PC_WIDTH    = 32,
  parameter  int BHT_ENTRIES = 64,
  localparam int IDX_W       = $clog2(BHT_ENTRIES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                f_valid,
  input  logic [PC_WIDTH-1:0] f_pc,
  output logic                f_ready,
  output logic                pred_valid,
  output logic                pred_taken,
  output logic [PC_WIDTH-1:0] pred_target,
  input  logic                r_valid,
  input  logic                r_is_branch,
  input  logic                r_is_jal,
  input  logic [PC_WIDTH-1:0] r_pc,
  input  logic                r_taken,
  input  logic [PC_WIDTH-1:0] r_target,
  input  logic                r_pred_taken,
  input  logic [PC_WIDTH-1:0] r_pred_target,
`ifdef BP_STATS_EN
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_mispredicts,
`endif
  output logic                mispredict,
  output logic [PC_WIDTH-1:0] redirect_pc
);
  localparam int TAG_W = PC_WIDTH - IDX_W - 2;
  bp_state_t             state, state_d;
  logic [IDX_W-1:0]      sweep;
  ctr_t                  bht     [BHT_ENTRIES];
  logic [TAG_W-1:0]      btb_tag [BHT_ENTRIES];
  logic [PC_WIDTH-1:0]   btb_tgt [BHT_ENTRIES];
  logic [BHT_ENTRIES-1:0] btb_v;
  logic                  run, accept, upd, mis_d, lk_taken, pv_q;
  logic [IDX_W-1:0]      f_idx, r_idx;
  logic [PC_WIDTH-1:0]   lk_target, redir_d;
  logic [1:0]            ctr_nxt;
  assign run     = state == RUN;
  assign f_ready = run;
  assign accept  = f_valid & run;
  assign f_idx   = f_pc[IDX_W+1:2];
  assign r_idx   = r_pc[IDX_W+1:2];
  // a BTB miss (invalid or aliased tag) always predicts fall-through
  assign lk_taken  = (bht[f_idx] >= WT) & btb_v[f_idx] & (btb_tag[f_idx] == f_pc[PC_WIDTH-1:IDX_W+2]);
  assign lk_target = lk_taken ? btb_tgt[f_idx] : f_pc + PC_WIDTH'(PC_STEP);
  assign upd       = run & r_valid & r_is_branch;
  assign mis_d     = upd & ((r_taken != r_pred_taken) | (r_taken & (r_target != r_pred_target)));
  assign redir_d   = r_taken ? r_target : r_pc + PC_WIDTH'(PC_STEP);
  // the prediction in flight during a redirect is stale and is dropped
  assign pred_valid = pv_q & ~mispredict;
  bp_sat_counter u_ctr (
    .cur      (bht[r_idx]),
    .taken    (r_taken),
    .force_st (r_is_jal),
    .nxt      (ctr_nxt)
  );
  always_comb begin
    state_d = state;
    if (state == INIT && sweep == IDX_W'(BHT_ENTRIES - 1)) state_d = RUN;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= INIT;
      sweep       <= '0;
      pv_q        <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      state      <= state_d;
      sweep      <= run ? sweep : sweep + 1'b1;
      pv_q       <= accept;
      mispredict <= mis_d;
      redirect_pc <= mis_d ? redir_d : '0;
      if (accept) begin
        pred_taken  <= lk_taken;
        pred_target <= lk_target;
      end
    end
  end
  // tables are cleared by the INIT sweep rather than by reset; reads above see pre-update contents
  always_ff @(posedge clk) begin
    if (!run) begin
      bht[sweep]   <= WNT;
      btb_v[sweep] <= 1'b0;
    end else if (upd) begin
      bht[r_idx] <= ctr_t'(ctr_nxt);
      if (r_taken) begin
        btb_v[r_idx]   <= 1'b1;
        btb_tag[r_idx] <= r_pc[PC_WIDTH-1:IDX_W+2];
        btb_tgt[r_idx] <= r_target;
      end
    end
  end
`ifdef BP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      stat_branches    <= stat_branches + 32'(upd);
      stat_mispredicts <= stat_mispredicts + 32'(mispredict);
    end
  end
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: scoreboard bench with a behavioural table model and directed + random stimulus
module tb_branch_predictor;
  localparam int N = 64;
  logic        clk = 0, rst_n = 0;
  logic        f_valid = 0, f_ready, pred_valid, pred_taken, mispredict;
  logic [31:0] f_pc = 0, pred_target, redirect_pc;
  logic        r_valid = 0, r_is_branch = 0, r_is_jal = 0, r_taken = 0, r_pred_taken = 0;
  logic [31:0] r_pc = 0, r_target = 0, r_pred_target = 0;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif
  branch_predictor dut (
    .clk(clk), .rst_n(rst_n), .f_valid(f_valid), .f_pc(f_pc), .f_ready(f_ready),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
    .r_valid(r_valid), .r_is_branch(r_is_branch), .r_is_jal(r_is_jal), .r_pc(r_pc),
    .r_taken(r_taken), .r_target(r_target), .r_pred_taken(r_pred_taken),
    .r_pred_target(r_pred_target),
`ifdef BP_STATS_EN
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts),
`endif
    .mispredict(mispredict), .redirect_pc(redirect_pc)
  );
  always #5 clk = ~clk;
  typedef struct {int due; logic tk; logic [31:0] tgt;} exp_t;
  exp_t        pq[$], mq[$];
  int          cyc = 0, checks = 0, errors = 0, edges = 0, m_br = 0, m_mis = 0;
  int          m_ctr[N];
  bit          m_v[N];
  logic [31:0] m_tag[N], m_tgt[N];
  logic        ep, em;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction
  // monitor: every output cycle is matched against the head of the expectation queues
  always @(posedge clk) begin
    cyc++;
    #1;
    ep = pq.size() > 0 && pq[0].due == cyc;
    em = mq.size() > 0 && mq[0].due == cyc;
    chk("pred_valid", {31'b0, pred_valid}, {31'b0, ep});
    chk("mispredict", {31'b0, mispredict}, {31'b0, em});
    if (ep) begin
      if (pred_valid) begin
        chk("pred_taken", {31'b0, pred_taken}, {31'b0, pq[0].tk});
        chk("pred_target", pred_target, pq[0].tgt);
      end
      void'(pq.pop_front());
    end
    if (em) begin
      if (mispredict) chk("redirect_pc", redirect_pc, mq[0].tgt);
      void'(mq.pop_front());
    end
  end
  task automatic cycle(input logic fv, input logic [31:0] fpc, input logic rv, rb, rj,
                       input logic [31:0] rpc, input logic rt, input logic [31:0] rtgt,
                       input logic rpt, input logic [31:0] rptgt);
    bit run, mis, tk, upd;
    int fi, ri;
    f_valid = fv; f_pc = fpc; r_valid = rv; r_is_branch = rb; r_is_jal = rj; r_pc = rpc;
    r_taken = rt; r_target = rtgt; r_pred_taken = rpt; r_pred_target = rptgt;
    run = edges >= N;
    chk("f_ready", {31'b0, f_ready}, {31'b0, run});
    fi = int'((fpc >> 2) % N);
    ri = int'((rpc >> 2) % N);
    upd = run && rv && rb;
    mis = upd && ((rt != rpt) || (rt && rtgt != rptgt));
    if (mis) mq.push_back('{cyc + 1, 1'b1, rt ? rtgt : rpc + 32'd4});
    if (run && fv && !mis) begin
      tk = m_ctr[fi] >= 2 && m_v[fi] && m_tag[fi] == (fpc >> 8);
      pq.push_back('{cyc + 1, tk, tk ? m_tgt[fi] : fpc + 32'd4});
    end
    @(posedge clk);
    edges++;
    if (upd) begin
      m_br++;
      if (mis) m_mis++;
      if (rj) m_ctr[ri] = 3;
      else if (rt) m_ctr[ri] = (m_ctr[ri] == 3) ? 3 : m_ctr[ri] + 1;
      else m_ctr[ri] = (m_ctr[ri] == 0) ? 0 : m_ctr[ri] - 1;
      if (rt) begin
        m_v[ri] = 1; m_tag[ri] = rpc >> 8; m_tgt[ri] = rtgt;
      end
    end
    if (edges == N) for (int i = 0; i < N; i++) begin m_ctr[i] = 1; m_v[i] = 0; end
    @(negedge clk);
  endtask
  task automatic look(input logic [31:0] pc);
    cycle(1, pc, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic resolve(input logic [31:0] pc, input logic rt, rj, input logic [31:0] tgt,
                         input logic rpt, input logic [31:0] rptgt);
    cycle(0, 0, 1, 1, rj, pc, rt, tgt, rpt, rptgt);
  endtask
  task automatic check_zero(string tag);
    chk({tag, "_pv"}, {31'b0, pred_valid}, 0);
    chk({tag, "_pt"}, {31'b0, pred_taken}, 0);
    chk({tag, "_ptgt"}, pred_target, 0);
    chk({tag, "_mis"}, {31'b0, mispredict}, 0);
    chk({tag, "_redir"}, redirect_pc, 0);
    chk({tag, "_rdy"}, {31'b0, f_ready}, 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] fp, rp, tg;
    logic rt, rj;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1; edges = 0;
    repeat (N) look(32'h100);
    look(32'h100);
    chk("init_nt_target", pred_target, 32'h104);
    resolve(32'h200, 1, 0, 32'h80, 0, 0);
    chk("tk_mis", {31'b0, mispredict}, 1);
    chk("tk_redir", redirect_pc, 32'h80);
    look(32'h200);
    chk("wt_taken", {31'b0, pred_taken}, 1);
    chk("wt_target", pred_target, 32'h80);
    resolve(32'h200, 0, 0, 0, 1, 32'h80);
    resolve(32'h200, 0, 0, 0, 0, 0);
    look(32'h200);
    chk("snt_taken", {31'b0, pred_taken}, 0);
    chk("snt_target", pred_target, 32'h204);
    resolve(32'h200, 0, 0, 0, 0, 0);
    resolve(32'h200, 1, 0, 32'h80, 0, 0);
    look(32'h200);
    chk("snt_sat", {31'b0, pred_taken}, 0);
    resolve(32'h300, 1, 1, 32'h40, 1, 32'h40);
    look(32'h300);
    chk("jal_taken", {31'b0, pred_taken}, 1);
    chk("jal_target", pred_target, 32'h40);
    look(32'h400);
    chk("alias_nt", {31'b0, pred_taken}, 0);
    chk("alias_tgt", pred_target, 32'h404);
    resolve(32'h300, 0, 0, 0, 0, 0);
    cycle(1, 32'h300, 1, 1, 0, 32'h300, 0, 0, 0, 0);
    chk("rbw_old", {31'b0, pred_taken}, 1);
    look(32'h300);
    chk("rbw_new", {31'b0, pred_taken}, 0);
    cycle(1, 32'h300, 1, 1, 0, 32'h300, 1, 32'h44, 0, 0);
    chk("squash_pv", {31'b0, pred_valid}, 0);
    chk("squash_mis", {31'b0, mispredict}, 1);
    for (int k = 0; k < 2000; k++) begin
      fp = 32'h1000 + (32'($urandom_range(0, 7)) << 2) + (($urandom_range(0, 3) == 0) ? 32'h100 : 0);
      rp = 32'h1000 + (32'($urandom_range(0, 7)) << 2) + (($urandom_range(0, 3) == 0) ? 32'h100 : 0);
      tg = $urandom & ~32'h3;
      rj = $urandom_range(0, 5) == 0;
      rt = rj | $urandom_range(0, 1);
      cycle($urandom_range(0, 1), fp, $urandom_range(0, 1), $urandom_range(0, 3) != 0, rj, rp, rt,
            tg, $urandom_range(0, 1), $urandom_range(0, 1) ? tg : $urandom);
    end
    look(32'h1000);
    rst_n = 0;
    pq.delete(); mq.delete();
    #1;
    check_zero("midrst");
    @(negedge clk);
    rst_n = 1; edges = 0; m_br = 0; m_mis = 0;
    repeat (N) look(32'h2000);
    look(32'h300);
    chk("rst_tbl_nt", {31'b0, pred_taken}, 0);
    resolve(32'h500, 1, 0, 32'h10, 1, 32'h10);
    resolve(32'h504, 1, 0, 32'h20, 0, 0);
    resolve(32'h508, 0, 0, 0, 0, 0);
    resolve(32'h500, 1, 0, 32'h10, 1, 32'h10);
    resolve(32'h50c, 0, 0, 0, 1, 32'h30);
    look(32'h500);
    look(32'h500);
    chk("stat_model_br", m_br, 5);
    chk("stat_model_mis", m_mis, 2);
`ifdef BP_STATS_EN
    chk("stat_branches", stat_branches, 5);
    chk("stat_mispredicts", stat_mispredicts, 2);
`endif
    look(32'h0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("drain_pq", pq.size(), 0);
    chk("drain_mq", mq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side branch predictor and mispredict detector; the counterpart of the execute-stage branch resolution logic.
- At fetch it predicts the direction and target for the current PC using a 2-bit saturating-counter branch history table (BHT) and a direct-mapped branch target buffer (BTB).
- At execute it accepts the resolved outcome (branch_or_not), trains the tables, and raises a one-cycle mispredict/redirect to the PC mux.

Parameters:
- PC_WIDTH, 32, PC and target width.
- BHT_ENTRIES, 64, entries in the BHT and BTB; power of two, minimum 4.
- IDX_W, $clog2(BHT_ENTRIES), index width; derived, do not override.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- f_valid  in  1  fetch lookup request
- f_pc  in  PC_WIDTH  fetch PC
- f_ready  out  1  predictor ready (0 during INIT)
- pred_valid  out  1  prediction valid, one cycle after an accepted f_valid
- pred_taken  out  1  predicted taken
- pred_target  out  PC_WIDTH  predicted next PC
- r_valid  in  1  resolution valid
- r_is_branch  in  1  instruction is a conditional branch or jal
- r_is_jal  in  1  instruction is jal
- r_pc  in  PC_WIDTH  PC of the resolved instruction
- r_taken  in  1  resolved outcome (branch_or_not)
- r_target  in  PC_WIDTH  resolved target
- r_pred_taken  in  1  prediction carried down the pipe
- r_pred_target  in  PC_WIDTH  predicted target carried down the pipe
- mispredict  out  1  one-cycle redirect pulse
- redirect_pc  out  PC_WIDTH  correct next PC, valid while mispredict=1

Behaviour:
- Reset: async, active-low. All outputs are 0, FSM enters INIT, and the sweep pointer is 0. Reset asserted mid-operation aborts everything and returns to INIT.
- FSM INIT: one table entry written per cycle (BHT entry = WNT 01, BTB valid = 0). f_ready=0, pred_valid=0, resolutions ignored. After entry BHT_ENTRIES-1 is written, move to RUN; INIT lasts exactly BHT_ENTRIES cycles.
- FSM RUN: f_ready=1. No other transitions except reset.
- Index = pc[IDX_W+1:2]; tag = pc[PC_WIDTH-1:IDX_W+2].
- Lookup (accepted when f_valid & f_ready): registered, latency 1.
  - Next cycle: pred_valid=1.
  - pred_taken = (counter >= WT) & BTB valid & tag match.
  - pred_target = BTB target if pred_taken, else f_pc+4 (mod 2^PC_WIDTH).
- Update (r_valid & r_is_branch in RUN), on the same clock edge as the resolution:
  - Counter increments on taken and decrements on not-taken, saturating at ST (11) and SNT (00).
  - r_is_jal forces the counter to ST.
  - When r_taken=1: write BTB tag, target and valid=1.
  - When r_taken=0: BTB entry unchanged.
- Mispredict: computed combinationally from the r_* inputs, registered, asserted the next cycle for exactly one cycle.
  - Condition: r_taken != r_pred_taken, or (r_taken & r_target != r_pred_target).
  - redirect_pc = r_taken ? r_target : r_pc+4.
  - Non-branch or r_valid=0: no update and no mispredict.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update value (read-before-write).
- Squash: in the cycle mispredict=1, pred_valid is forced to 0 (the in-flight prediction is discarded).
- Aliasing: a tag mismatch is a BTB miss and predicts not-taken, whatever the counter value.

Optional Feature:
- Macro BP_STATS_EN.
- Defined: adds outputs stat_branches and stat_mispredicts, each 32 bits.
  - stat_branches counts every update; stat_mispredicts counts every mispredict pulse.
  - Both wrap at 2^32 and are async-cleared by rst_n.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- branch_pkg holds:
  - typedef enum logic[1:0] ctr_t: SNT=00, WNT=01, WT=10, ST=11.
  - typedef enum bp_state_t: INIT, RUN.
  - constant PC_STEP=4.
- Sub-module bp_sat_counter: combinational next-state of one ctr_t, with inputs taken and force_st. The top level instantiates it once, on the update path.

Test Plan:
- Reset, then hold f_valid=1 → f_ready=0 for exactly 64 cycles; then any PC predicts not-taken with target f_pc+4 (e.g. 0x100 → 0x104).
- Resolve branch at 0x200, taken, target 0x80, r_pred_taken=0 → mispredict=1 one cycle later with redirect_pc=0x80. Next lookup of 0x200 → pred_taken=1 (counter WT), pred_target=0x80.
- Two further not-taken resolutions of 0x200 → counter steps WT→WNT→SNT; the second lookup predicts not-taken, target 0x204. A not-taken resolution while at SNT keeps SNT.
- jal at 0x300 → 0x40 → counter ST immediately; lookup predicts taken 0x40. Lookup of the alias 0x300+(64<<2) → miss, not-taken.
- Lookup and update of the same index in the same cycle → pred_taken reflects the old counter. A mispredict cycle → pred_valid=0. rst_n low mid-RUN → all outputs 0 and INIT restarts.
- With BP_STATS_EN: 5 branch resolutions, 2 of them mispredicted → stat_branches=5, stat_mispredicts=2.
